stack_unit: RTL

Hardware stack storage for the 16-bit processor. This is the data end of the push/pop interface whose pointer side is the stack pointer.
- Accepts push/pop strobes from the control unit.
- Writes push data into an internal RAM and returns pop data one cycle later.
- Presents the architectural SP value (downward-growing) together with full/empty and sticky error status.

---
 rtl/stack_pkg.sv | 22 ++
 rtl/stack_ram.sv | 25 ++
 rtl/stack_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared types and constants for the hardware stack: op decode, count width, default SP.
package stack_pkg;

   localparam logic [15:0] SP_TOP_DEF = 16'hFFFF;

   // Encoding is the raw {push,pop} pair so decode is a plain cast.
   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_PUSH = 2'b10,
      OP_POP  = 2'b01,
      OP_SWAP = 2'b11
   } op_t;

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic op_t decode_op(input logic push, input logic pop);
      return op_t'({push, pop});
   endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x DATA_W stack storage: one synchronous write port, one registered read port, no reset.
// Read-before-write on the same address returns the old word, which the swap operation relies on.
module stack_ram #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/stack_unit.sv
// Data end of the processor stack: count, downward-growing SP decode, sticky over/underflow flags.
// Define STACK_HWM_EN to add the hwm output (maximum count reached since reset).
module stack_unit
   import stack_pkg::*;
#(
   parameter int                DATA_W = 16,
   parameter int                DEPTH  = 16,
   parameter int                ADDR_W = 16,
   parameter logic [ADDR_W-1:0] SP_TOP = ADDR_W'(SP_TOP_DEF)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic                      pop,
   input  logic [DATA_W-1:0]         wr_data,
   input  logic                      err_clr,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      rd_valid,
   output logic [ADDR_W-1:0]         sp,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      empty,
   output logic                      full,
   output logic                      ovf_err,
   output logic                      udf_err
`ifdef STACK_HWM_EN
   ,
   output logic [cnt_w(DEPTH)-1:0]   hwm
`endif
);

   localparam int CNT_W = cnt_w(DEPTH);
   localparam int AW    = $clog2(DEPTH);

   logic [CNT_W-1:0]  count_reg, count_next;
   logic              ovf_reg, ovf_next, udf_reg, udf_next;
   logic              rd_valid_reg, rd_valid_next;
   logic              rd_loaded_reg;
   logic              ovf_set, udf_set;
   logic              we, re;
   logic [AW-1:0]     waddr, top_addr;
   logic [DATA_W-1:0] ram_q;
   op_t               op;

   assign op       = decode_op(push, pop);
   assign empty    = (count_reg == '0);
   assign full     = (count_reg == CNT_W'(DEPTH));
   assign top_addr = AW'(count_reg - CNT_W'(1));

   always_comb begin
      count_next    = count_reg;
      we            = 1'b0;
      re            = 1'b0;
      waddr         = count_reg[AW-1:0];
      rd_valid_next = 1'b0;
      ovf_set       = 1'b0;
      udf_set       = 1'b0;
      case (op)
         OP_PUSH: begin
            if (full) begin
               ovf_set = 1'b1;
            end else begin
               we         = 1'b1;
               count_next = count_reg + CNT_W'(1);
            end
         end
         OP_POP: begin
            if (empty) begin
               udf_set = 1'b1;
            end else begin
               re            = 1'b1;
               rd_valid_next = 1'b1;
               count_next    = count_reg - CNT_W'(1);
            end
         end
         OP_SWAP: begin
            // Swap overwrites the top entry while the RAM reads its old contents.
            if (empty) begin
               udf_set = 1'b1;
            end else begin
               we            = 1'b1;
               waddr         = top_addr;
               re            = 1'b1;
               rd_valid_next = 1'b1;
            end
         end
         default: ;
      endcase
      ovf_next = ovf_set | (ovf_reg & ~err_clr);
      udf_next = udf_set | (udf_reg & ~err_clr);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg     <= '0;
         ovf_reg       <= 1'b0;
         udf_reg       <= 1'b0;
         rd_valid_reg  <= 1'b0;
         rd_loaded_reg <= 1'b0;
      end else begin
         count_reg     <= count_next;
         ovf_reg       <= ovf_next;
         udf_reg       <= udf_next;
         rd_valid_reg  <= rd_valid_next;
         if (re)
            rd_loaded_reg <= 1'b1;
      end
   end

   stack_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wr_data),
      .re    (re),
      .raddr (top_addr),
      .rdata (ram_q)
   );

   // The RAM output has no reset, so rd_data reads as zero until the first successful pop.
   assign rd_data  = rd_loaded_reg ? ram_q : '0;
   assign rd_valid = rd_valid_reg;
   assign count    = count_reg;
   assign sp       = SP_TOP - ADDR_W'(count_reg);
   assign ovf_err  = ovf_reg;
   assign udf_err  = udf_reg;

`ifdef STACK_HWM_EN
   logic [CNT_W-1:0] hwm_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         hwm_reg <= '0;
      else if (count_next > hwm_reg)
         hwm_reg <= count_next;
   end

   assign hwm = hwm_reg;
`endif

endmodule
